// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        HOLD  = 2'd2,
        RET   = 2'd3
    } int_state_e;

    localparam logic [2:0] FW_REG = 3'd0;
    localparam logic [2:0] FW_EXE = 3'd1;
    localparam logic [2:0] FW_MEM = 3'd2;
    localparam logic [2:0] FW_DIN = 3'd3;
    localparam logic [2:0] FW_CP0 = 3'd4;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forward select for one ID source operand, plus a load-use flag for that operand.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] src,
    input  logic             used,
    input  logic [REG_W-1:0] wa_exe,
    input  logic             we_exe,
    input  logic             ld_exe,
    input  logic [REG_W-1:0] wa_mem,
    input  logic             we_mem,
    input  logic             ld_mem,
    output logic [2:0]       sel,
    output logic             ld_hz
);

    logic nz;
    logic hit_exe;
    logic hit_mem;

    assign nz      = (src != '0);
    assign hit_exe = nz && we_exe && (wa_exe == src);
    assign hit_mem = nz && we_mem && (wa_mem == src);
    assign ld_hz   = used && hit_exe && ld_exe;

    always_comb begin
        sel = FW_REG;
        if (hit_exe && !ld_exe) begin
            sel = FW_EXE;
        end else if (hit_mem) begin
            sel = ld_mem ? FW_DIN : FW_MEM;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enables/flushes, forwarding, load-use stalls, branch flush and
// interrupt/ERET redirect sequencing for the 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int INT_HOLD = 3,
    parameter int REG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             rs_used,
    input  logic             rt_used,
    input  logic             rt_is_store,
    input  logic             mfc0_id,
    input  logic [REG_W-1:0] wa_exe,
    input  logic             we_exe,
    input  logic             ld_exe,
    input  logic [REG_W-1:0] wa_mem,
    input  logic             we_mem,
    input  logic             ld_mem,
    input  logic [1:0]       branch_mem,
    input  logic             irq,
    input  logic             eret_id,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_valid,
    output logic [1:0]       ForwardA,
    output logic [2:0]       ForwardB,
    output logic             ForwardM,
    output logic             jump_en,
    output logic             return_en,
    output logic             int_ack,
    output logic             data_stall,
    output logic             branch_stall,
    output logic [1:0]       int_state
);

    localparam int CW = (INT_HOLD < 2) ? 1 : $clog2(INT_HOLD + 1);

    int_state_e    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          irq_pend, irq_pend_n;

    logic [2:0] sel_rs, sel_rt;
    logic       hz_rs, hz_rt;
    logic       int_flush, br_flush, load_use, st_hit;

    fwd_sel #(.REG_W(REG_W)) u_fwd_rs (
        .src(rs_id), .used(rs_used),
        .wa_exe(wa_exe), .we_exe(we_exe), .ld_exe(ld_exe),
        .wa_mem(wa_mem), .we_mem(we_mem), .ld_mem(ld_mem),
        .sel(sel_rs), .ld_hz(hz_rs)
    );

    fwd_sel #(.REG_W(REG_W)) u_fwd_rt (
        .src(rt_id), .used(rt_used),
        .wa_exe(wa_exe), .we_exe(we_exe), .ld_exe(ld_exe),
        .wa_mem(wa_mem), .we_mem(we_mem), .ld_mem(ld_mem),
        .sel(sel_rt), .ld_hz(hz_rt)
    );

    assign int_flush = (state == REDIR) || (state == RET);
    assign br_flush  = |branch_mem;
    // Store data hazards are resolved by ForwardM, not by a bubble.
    assign load_use  = hz_rs || (hz_rt && !rt_is_store);
    assign st_hit    = rt_is_store && ld_exe && we_exe &&
                       (wa_exe != '0) && (wa_exe == rt_id);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            irq_pend <= irq_pend_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        irq_pend_n = irq_pend || irq;
        unique case (state)
            IDLE: begin
                if ((irq || irq_pend) && !br_flush) begin
                    state_n    = REDIR;
                    irq_pend_n = 1'b0;
                end else if (eret_id && !br_flush) begin
                    state_n = RET;
                end
            end
            REDIR, RET: begin
                state_n = HOLD;
                cnt_n   = CW'(INT_HOLD);
            end
            HOLD: begin
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        if_en        = 1'b1;
        id_en        = 1'b1;
        exe_en       = 1'b1;
        mem_en       = 1'b1;
        wb_en        = 1'b1;
        if_rst       = 1'b0;
        id_rst       = 1'b0;
        exe_rst      = 1'b0;
        mem_rst      = 1'b0;
        wb_rst       = 1'b0;
        if_valid     = 1'b1;
        ForwardA     = sel_rs[1:0];
        ForwardB     = mfc0_id ? FW_CP0 : sel_rt;
        ForwardM     = !st_hit;
        jump_en      = (state == REDIR);
        int_ack      = (state == REDIR);
        return_en    = (state == RET);
        data_stall   = 1'b0;
        branch_stall = 1'b0;
        if (rst) begin
            {if_en, id_en, exe_en, mem_en, wb_en}      = '0;
            {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = '1;
            if_valid  = 1'b0;
            ForwardA  = '0;
            ForwardB  = '0;
            ForwardM  = 1'b1;
            jump_en   = 1'b0;
            int_ack   = 1'b0;
            return_en = 1'b0;
        end else begin
            priority case (1'b1)
                int_flush: begin
                    {id_rst, exe_rst, mem_rst} = '1;
                end
                br_flush: begin
                    {id_rst, exe_rst, mem_rst} = '1;
                    branch_stall = 1'b1;
                end
                load_use: begin
                    if_en      = 1'b0;
                    id_en      = 1'b0;
                    exe_rst    = 1'b1;
                    data_stall = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign int_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases then random traffic.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_id, rt_id, wa_exe, wa_mem;
    logic       rs_used, rt_used, rt_is_store, mfc0_id;
    logic       we_exe, ld_exe, we_mem, ld_mem, irq, eret_id;
    logic [1:0] branch_mem;
    logic       if_en, id_en, exe_en, mem_en, wb_en;
    logic       if_rst, id_rst, exe_rst, mem_rst, wb_rst;
    logic       if_valid, ForwardM, jump_en, return_en, int_ack;
    logic       data_stall, branch_stall;
    logic [1:0] ForwardA, int_state;
    logic [2:0] ForwardB;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.INT_HOLD(3), .REG_W(5)) dut (
        .clk(clk), .rst(rst),
        .rs_id(rs_id), .rt_id(rt_id),
        .rs_used(rs_used), .rt_used(rt_used),
        .rt_is_store(rt_is_store), .mfc0_id(mfc0_id),
        .wa_exe(wa_exe), .we_exe(we_exe), .ld_exe(ld_exe),
        .wa_mem(wa_mem), .we_mem(we_mem), .ld_mem(ld_mem),
        .branch_mem(branch_mem), .irq(irq), .eret_id(eret_id),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en),
        .mem_en(mem_en), .wb_en(wb_en),
        .if_rst(if_rst), .id_rst(id_rst), .exe_rst(exe_rst),
        .mem_rst(mem_rst), .wb_rst(wb_rst),
        .if_valid(if_valid),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .ForwardM(ForwardM),
        .jump_en(jump_en), .return_en(return_en), .int_ack(int_ack),
        .data_stall(data_stall), .branch_stall(branch_stall),
        .int_state(int_state)
    );

    logic [23:0] act;
    assign act = {if_en, id_en, exe_en, mem_en, wb_en,
                  if_rst, id_rst, exe_rst, mem_rst, wb_rst,
                  if_valid, ForwardA, ForwardB, ForwardM,
                  jump_en, return_en, int_ack,
                  data_stall, branch_stall, int_state};

    logic [23:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model state: mode 0 idle, 1 entering, 2 waiting, 3 returning.
    int mode = 0;
    int left = 0;
    bit pend = 0;

    function automatic logic [2:0] fw(input logic [4:0] r);
        if (r == 0) return 3'd0;
        if (we_exe && wa_exe == r && !ld_exe) return 3'd1;
        if (we_mem && wa_mem == r) return ld_mem ? 3'd3 : 3'd2;
        return 3'd0;
    endfunction

    task automatic clr();
        rs_id = 0; rt_id = 0; wa_exe = 0; wa_mem = 0;
        rs_used = 0; rt_used = 0; rt_is_store = 0; mfc0_id = 0;
        we_exe = 0; ld_exe = 0; we_mem = 0; ld_mem = 0;
        irq = 0; eret_id = 0; branch_mem = 0;
    endtask

    task automatic step();
        logic [4:0] en, fl;
        logic       ifv, fm, j, r, a, ds, bs;
        logic [1:0] fa;
        logic [2:0] fb;
        bit         br, lu, take;
        br = (branch_mem != 0);
        lu = ld_exe && we_exe && wa_exe != 0 &&
             ((rs_used && wa_exe == rs_id) ||
              (rt_used && !rt_is_store && wa_exe == rt_id));
        if (rst) begin
            en = 0; fl = 5'b11111; ifv = 0; fa = 0; fb = 0; fm = 1;
            j = 0; r = 0; a = 0; ds = 0; bs = 0;
            exp_q.push_back({en, fl, ifv, fa, fb, fm, j, r, a, ds, bs, 2'd0});
            mode = 0; left = 0; pend = 0;
        end else begin
            en = 5'b11111; fl = 0; ifv = 1; ds = 0; bs = 0;
            fa = fw(rs_id);
            fb = mfc0_id ? 3'd4 : fw(rt_id);
            fm = !(rt_is_store && ld_exe && we_exe && wa_exe != 0 && wa_exe == rt_id);
            j = (mode == 1); a = (mode == 1); r = (mode == 3);
            if (mode == 1 || mode == 3) fl = 5'b01110;
            else if (br) begin fl = 5'b01110; bs = 1; end
            else if (lu) begin en = 5'b00111; fl = 5'b00100; ds = 1; end
            exp_q.push_back({en, fl, ifv, fa, fb, fm, j, r, a, ds, bs, 2'(mode)});
            case (mode)
                0: begin
                    take = (irq || pend) && !br;
                    if (take) begin mode = 1; pend = 0; end
                    else begin
                        pend = pend || irq;
                        if (eret_id && !br) mode = 3;
                    end
                end
                1, 3: begin mode = 2; left = 3; pend = pend || irq; end
                default: begin
                    pend = pend || irq;
                    left = left - 1;
                    if (left == 0) mode = 0;
                end
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL cycle%0d outputs: got=%h want=%h", cyc, act, e);
                end
            end
        end
    end

    logic [4:0] pick[4];

    initial begin
        pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd9; pick[3] = 5'd3;
        clr();
        rst = 1;
        @(negedge clk);
        step(); step();
        rst = 0;
        step();
        clr(); we_exe = 1; wa_exe = 8; rs_id = 8; rs_used = 1; step();
        clr(); we_mem = 1; wa_mem = 8; rs_id = 8; rs_used = 1; step();
        clr(); ld_exe = 1; we_exe = 1; wa_exe = 9; rt_id = 9; rt_used = 1; step();
        clr(); ld_mem = 1; we_mem = 1; wa_mem = 9; rt_id = 9; rt_used = 1; step();
        clr(); ld_exe = 1; we_exe = 1; wa_exe = 9; rt_id = 9; rt_used = 1;
        rt_is_store = 1; step();
        clr(); mfc0_id = 1; we_exe = 1; wa_exe = 4; rt_id = 4; step();
        clr(); ld_exe = 1; we_exe = 1; wa_exe = 0; rs_id = 0; rs_used = 1; step();
        clr(); branch_mem = 2'b01; step();
        clr(); step();
        clr(); irq = 1; branch_mem = 2'b10; step();
        clr(); repeat (6) step();
        clr(); eret_id = 1; step();
        clr(); ld_exe = 1; we_exe = 1; wa_exe = 8; rs_id = 8; rs_used = 1; step();
        clr(); repeat (5) step();
        clr(); irq = 1; step();
        clr(); step(); step();
        rst = 1; step();
        rst = 0; step(); step();
        for (int i = 0; i < 600; i++) begin
            rs_id = pick[$urandom_range(0, 3)];
            rt_id = pick[$urandom_range(0, 3)];
            wa_exe = pick[$urandom_range(0, 3)];
            wa_mem = pick[$urandom_range(0, 3)];
            rs_used = 1'($urandom);
            rt_used = 1'($urandom);
            rt_is_store = ($urandom_range(0, 3) == 0);
            mfc0_id = ($urandom_range(0, 7) == 0);
            we_exe = 1'($urandom);
            ld_exe = 1'($urandom);
            we_mem = 1'($urandom);
            ld_mem = 1'($urandom);
            irq = ($urandom_range(0, 15) == 0);
            eret_id = ($urandom_range(0, 15) == 0);
            branch_mem = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;
        clr();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #4;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
